// File: rtl/reset_sequencer_if.sv
// Handshake and reset-output bundle between the reset sequencer and its consumers.
// The slave side is the sequencer; the master side requests software resets.
interface reset_sequencer_if #(
    parameter int NUM_OUT = 4
);
    logic               sw_rst_req;
    logic [NUM_OUT-1:0] rst_n_out;
    logic               rst_done;
    logic               sw_rst_ack;

    modport master (
        output sw_rst_req,
        input  rst_n_out,
        input  rst_done,
        input  sw_rst_ack
    );

    modport slave (
        input  sw_rst_req,
        output rst_n_out,
        output rst_done,
        output sw_rst_ack
    );
endinterface

// File: rtl/reset_sequencer.sv
// Asynchronously asserted, synchronously released reset sequencer producing NUM_OUT
// staggered active-low resets, with a software-triggered re-run of the hold/release sequence.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_OUT     = 4,
    parameter int STAGE_GAP   = 4,
    parameter int CNT_W       = 8
) (
    input  logic             sys_clk,
    input  logic             sys_resetn,
    reset_sequencer_if.slave bus
);
    // The FSM state register acts as the last synchronizer flop, so the chain itself is one shorter.
    localparam int SW    = SYNC_STAGES - 1;
    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    typedef enum logic [1:0] {SYNC, HOLD, RELEASE, DONE} state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      sync_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_OUT-1:0] rst_n_q, rst_n_d;
    logic               done_q, done_d;
    logic               ack_q, ack_d;

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            sync_q  <= '0;
            state_q <= SYNC;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            sync_q  <= (sync_q << 1) | SW'(1);
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;
        done_d  = done_q;
        ack_d   = 1'b0;
        case (state_q)
            SYNC: begin
                if (sync_q[SW-1]) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    rst_n_d = NUM_OUT'(1);
                    cnt_d   = '0;
                    idx_d   = IDX_W'(1);
                    if (NUM_OUT == 1) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                // Bits release strictly in order, so shifting in a one releases bit idx_q.
                if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                    rst_n_d = (rst_n_q << 1) | NUM_OUT'(1);
                    cnt_d   = '0;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NUM_OUT - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.sw_rst_req) begin
                    rst_n_d = '0;
                    done_d  = 1'b0;
                    ack_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    assign bus.rst_n_out  = rst_n_q;
    assign bus.rst_done   = done_q;
    assign bus.sw_rst_ack = ack_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance plus a NUM_OUT=1/HOLD_CYCLES=1 corner instance,
// both compared every cycle against an edge-count reference model.
`timescale 1ns/100ps
module tb_reset_sequencer;
  localparam int SYNC_STAGES = 2;
  localparam int HOLD_CYCLES = 16;
  localparam int NUM_OUT     = 4;
  localparam int STAGE_GAP   = 4;

  logic sys_clk = 1'b0;
  logic sys_resetn;
  always #1 sys_clk = ~sys_clk;

  reset_sequencer_if #(.NUM_OUT(NUM_OUT)) bus ();
  reset_sequencer_if #(.NUM_OUT(1))       bus_c ();

  reset_sequencer #(
    .SYNC_STAGES(SYNC_STAGES), .HOLD_CYCLES(HOLD_CYCLES), .NUM_OUT(NUM_OUT),
    .STAGE_GAP(STAGE_GAP), .CNT_W(8)
  ) dut (
    .sys_clk(sys_clk), .sys_resetn(sys_resetn), .bus(bus)
  );

  reset_sequencer #(
    .SYNC_STAGES(2), .HOLD_CYCLES(1), .NUM_OUT(1), .STAGE_GAP(4), .CNT_W(8)
  ) dut_c (
    .sys_clk(sys_clk), .sys_resetn(sys_resetn), .bus(bus_c)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: e = rising edges since reset release; anchor = edge that starts the hold.
  int               e;
  bit               av;
  int               anchor;
  logic [NUM_OUT-1:0] m_out;
  bit               m_done, m_ack, c_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    e = 0; av = 0; anchor = 0; m_out = '0; m_done = 0; m_ack = 0; c_out = 0;
  endtask

  task automatic model_edge();
    bit accept;
    if (!sys_resetn) begin
      model_reset();
      return;
    end
    e++;
    accept = m_done && (bus.sw_rst_req === 1'b1);
    m_ack  = accept;
    if (accept) anchor = e;
    else if (e == SYNC_STAGES) begin
      av = 1; anchor = e;
    end
    for (int i = 0; i < NUM_OUT; i++)
      m_out[i] = av && (e >= anchor + HOLD_CYCLES + i * STAGE_GAP);
    m_done = &m_out;
    c_out  = (e >= SYNC_STAGES + 1);
  endtask

  task automatic compare_all();
    chk("rst_n_out",   32'(bus.rst_n_out),   32'(m_out));
    chk("rst_done",    32'(bus.rst_done),    32'(m_done));
    chk("sw_rst_ack",  32'(bus.sw_rst_ack),  32'(m_ack));
    chk("c_rst_n_out", 32'(bus_c.rst_n_out), 32'(c_out));
    chk("c_rst_done",  32'(bus_c.rst_done),  32'(c_out));
  endtask

  // Called at a falling edge: drive request, model the rising edge, compare at the next falling edge.
  task automatic cycle(input bit req);
    bus.sw_rst_req = req;
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    compare_all();
  endtask

  task automatic glitch();
    #0.3 sys_resetn = 1'b0;
    #0.1 model_reset();
    compare_all();
    chk("glitch_zero", 32'(bus.rst_n_out), 32'h0);
    #0.3 sys_resetn = 1'b1;
  endtask

  // Full sequence from reset release; optionally holds the request high from E5 to E25.
  task automatic powerup_run(input bit hold_req);
    int acks;
    acks = 0;
    for (int k = 1; k <= 32; k++) begin
      cycle(hold_req && k >= 5 && k <= 25);
      if (bus.sw_rst_ack === 1'b1) acks++;
      case (k)
        17: chk("E17_out", 32'(bus.rst_n_out), 32'h0);
        18: chk("E18_out", 32'(bus.rst_n_out), 32'h1);
        22: chk("E22_out", 32'(bus.rst_n_out), 32'h3);
        26: chk("E26_out", 32'(bus.rst_n_out), 32'h7);
        29: chk("E29_done", 32'(bus.rst_done), 32'h0);
        30: begin
          chk("E30_out", 32'(bus.rst_n_out), 32'hf);
          chk("E30_done", 32'(bus.rst_done), 32'h1);
        end
        default: ;
      endcase
      if (k == 3) chk("E3_corner", 32'(bus_c.rst_done), 32'h1);
    end
    chk("pwr_acks", 32'(acks), 32'h0);
  endtask

  initial begin
    int acks, dones;
    sys_resetn       = 1'b1;
    bus.sw_rst_req   = 1'b0;
    bus_c.sw_rst_req = 1'b0;
    model_reset();

    #30 sys_resetn = 1'b0;
    #0.5 compare_all();
    #49.5 sys_resetn = 1'b1;
    powerup_run(1'b0);

    // Abort while rst_n_out = 0001, then restart.
    glitch();
    for (int k = 1; k <= 20; k++) cycle(1'b0);
    chk("pre_abort", 32'(bus.rst_n_out), 32'h1);
    #0.3 sys_resetn = 1'b0;
    #0.1 model_reset();
    compare_all();
    cycle(1'b0);
    cycle(1'b0);
    sys_resetn = 1'b1;
    powerup_run(1'b0);

    // Ignored request during the sequence.
    glitch();
    powerup_run(1'b1);

    // Single software reset pulse in DONE.
    cycle(1'b1);
    chk("sw_ack_K", 32'(bus.sw_rst_ack), 32'h1);
    chk("sw_out_K", 32'(bus.rst_n_out), 32'h0);
    for (int k = 1; k <= 28; k++) begin
      cycle(1'b0);
      if (k == 1)  chk("sw_ack_K1", 32'(bus.sw_rst_ack), 32'h0);
      if (k == 16) chk("sw_K16", 32'(bus.rst_n_out), 32'h1);
      if (k == 27) chk("sw_K27", 32'(bus.rst_done), 32'h0);
    end
    chk("sw_K28_out", 32'(bus.rst_n_out), 32'hf);
    chk("sw_K28_done", 32'(bus.rst_done), 32'h1);

    // Request held permanently: one ack and one DONE cycle per 29-cycle loop.
    acks = 0; dones = 0;
    for (int k = 1; k <= 87; k++) begin
      cycle(1'b1);
      if (bus.sw_rst_ack === 1'b1) acks++;
      if (bus.rst_done === 1'b1) dones++;
    end
    chk("held_acks", 32'(acks), 32'd3);
    chk("held_dones", 32'(dones), 32'd3);
    cycle(1'b0);

    // Sub-period glitch forces a full restart.
    glitch();
    powerup_run(1'b0);

    // Random requests with occasional reset glitches.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) glitch();
      cycle($urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Consumes the raw system clock and active-low reset from the system-signal generator. It produces NUM_OUT staggered, synchronously-released reset outputs for the downstream blocks. Assertion is asynchronous; release is synchronized through a SYNC_STAGES flop chain, stretched by HOLD_CYCLES, then applied one output at a time every STAGE_GAP cycles. A single-cycle-handshake software reset request re-runs the hold/release sequence without toggling sys_resetn.

## Interface
- SYNC_STAGES, 2, depth of the reset-release synchronizer chain (>= 2)
- HOLD_CYCLES, 16, cycles between synchronized release and the first output release (>= 1)
- NUM_OUT, 4, number of sequenced reset outputs (>= 1)
- STAGE_GAP, 4, cycles between consecutive output releases (>= 1)
- CNT_W, 8, counter width; must hold max(HOLD_CYCLES, STAGE_GAP)
- sys_clk  input  1  single clock; all logic on its rising edge
- sys_resetn  input  1  asynchronous, active-low reset
- sw_rst_req  input  1  synchronous software reset request, level-sampled
- rst_n_out  output  NUM_OUT  sequenced active-low resets; bit 0 released first
- rst_done  output  1  high when every rst_n_out bit is released
- sw_rst_ack  output  1  one-cycle pulse when sw_rst_req is accepted

## Operation
- States: SYNC, HOLD, RELEASE, DONE.
- sys_resetn low, asynchronously:
  - sync chain cleared, state = SYNC, counters = 0
  - rst_n_out = 0, rst_done = 0, sw_rst_ack = 0
  - outputs are undefined until the first reset assertion; benches must assert reset first.
- SYNC: a constant 1 shifts through the chain.
  - When the chain output reaches 1, go to HOLD with the counter loaded to 0.
- HOLD: increment the counter each cycle.
  - On the cycle the counter reaches HOLD_CYCLES-1, set rst_n_out[0] = 1 and go to RELEASE with index = 1 and counter = 0.
  - If NUM_OUT = 1, go directly to DONE instead.
- RELEASE: increment the counter.
  - At STAGE_GAP-1, set rst_n_out[index] = 1, clear the counter, and increment index.
  - Releasing bit NUM_OUT-1 moves to DONE.
- DONE: rst_done = 1, set on the same edge that releases the last bit.
- Released bits stay released until sys_resetn is asserted or a software reset is accepted.
- Software reset:
  - sw_rst_req is sampled only in DONE.
  - On an edge with sw_rst_req = 1 in DONE: rst_n_out = 0, rst_done = 0, sw_rst_ack = 1 for exactly one cycle, state = HOLD, counter = 0.
  - The sync chain is not touched.
  - sw_rst_req high in any other state is ignored and not queued, and no ack is given.
  - A request held high continuously re-triggers on each return to DONE.
- Reset mid-sequence: sys_resetn assertion in any state, including mid-HOLD or RELEASE, aborts immediately to the reset values. The full sequence restarts from SYNC on release.
- A sys_resetn glitch shorter than one clock period still forces a full restart.
- rst_n_out bits are driven directly from flops, with no combinational path from sw_rst_req or state decode.

## Timing
- Let E1 be the first rising edge with sys_resetn sampled high.
- Synchronized release at edge E(SYNC_STAGES).
- rst_n_out[i] rises at edge E(SYNC_STAGES + HOLD_CYCLES + i*STAGE_GAP).
- rst_done rises with rst_n_out[NUM_OUT-1].
- Defaults: bit0 at E18, bit1 at E22, bit2 at E26, bit3 and rst_done at E30.
- Software reset accepted at edge K:
  - outputs fall after K; sw_rst_ack is high from K to K+1
  - bit i rises at K + HOLD_CYCLES + i*STAGE_GAP (defaults: K+16, K+20, K+24, K+28)
- Reset assertion: all outputs low within the same timestep as the sys_resetn falling edge, with no clock required.

## Test plan
- Power-up: the generator drives sys_resetn high 30, low 50, then high with a 2-unit clock period -> with defaults, rst_n_out goes 0000 -> 0001 at E18, 0011 at E22, 0111 at E26, 1111 with rst_done = 1 at E30; sw_rst_ack stays 0.
- Mid-sequence abort: assert sys_resetn low between E20 and E21 (rst_n_out = 0001) -> all outputs 0 immediately; after release the sequence restarts with bit0 at the new E18.
- Software reset: pulse sw_rst_req for one cycle at edge K in DONE -> sw_rst_ack = 1 for one cycle; rst_n_out = 0000 and rst_done = 0 after K; 1111 at K+28.
- Ignored request: hold sw_rst_req = 1 from E5 to E25 -> sequence timing identical to power-up and sw_rst_ack never asserts.
- Held request: keep sw_rst_req = 1 permanently after DONE -> one ack every 29 cycles (1 DONE cycle + 28 sequence cycles); rst_done is high for one cycle each loop.
- Parameter corner: NUM_OUT = 1, HOLD_CYCLES = 1, SYNC_STAGES = 2 -> rst_n_out[0] and rst_done rise together at E3.
